// File: rtl/structure_queue.sv
// Circular-buffer queue of packed {a, b} records; b is offset by in_int on push,
// and out_int accumulates the a field of every popped record.
package structure_queue_pkg;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } StructType;
endpackage

module structure_queue
    import structure_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  StructType                    in_struct,
    input  logic [31:0]                  in_int,
    output logic                         out_valid,
    input  logic                         out_ready,
    output StructType                    out_struct,
    output logic [31:0]                  out_int,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    StructType        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    // Handshake qualifiers depend only on the registered count, never on out_ready.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        out_struct = '0;
        if (out_valid) begin
            out_struct = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_struct.a, b: in_struct.b + in_int};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_int <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                out_int <= out_int + mem[rd_ptr].a;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_structure_queue.sv
// Directed self-checking bench for structure_queue with DEPTH = 4.
module tb_structure_queue;
    import structure_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    StructType   in_struct;
    logic [31:0] in_int;
    logic        out_valid;
    logic        out_ready;
    StructType   out_struct;
    logic [31:0] out_int;
    logic [2:0]  count;

    int unsigned n_checks;
    int unsigned n_errors;

    structure_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_struct  (in_struct),
        .in_int     (in_int),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_struct (out_struct),
        .out_int    (out_int),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_count"},      64'(count),     64'd0);
        check({tag, "_out_valid"},  64'(out_valid), 64'd0);
        check({tag, "_in_ready"},   64'(in_ready),  64'd1);
        check({tag, "_out_struct"}, out_struct,     64'd0);
        check({tag, "_out_int"},    64'(out_int),   64'd0);
    endtask

    StructType   exp_q[$];
    StructType   head;
    logic [31:0] sum_a;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_struct = '0;
        in_int    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");

        // Pop request on empty queue has no effect.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("empty_pop_count", 64'(count),   64'd0);
        check("empty_pop_int",   64'(out_int), 64'd0);

        // Single transfer.
        in_valid  = 1'b1;
        in_struct = '{a: 32'd5, b: 32'd7};
        in_int    = 32'd3;
        step();
        in_valid  = 1'b0;
        in_int    = '0;
        check("single_struct", out_struct,     {32'd5, 32'd10});
        check("single_count",  64'(count),     64'd1);
        check("single_valid",  64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_out_int", 64'(out_int), 64'd5);
        check("single_count0",  64'(count),   64'd0);
        check("single_struct0", out_struct,   64'd0);

        // Fill and block.
        pulse_reset();
        for (int i = 1; i <= 4; i++) begin
            in_valid  = 1'b1;
            in_struct = '{a: 32'(i), b: 32'(100 + i)};
            step();
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_count",    64'(count),    64'd4);
        in_struct = '{a: 32'd99, b: 32'd0};
        step();
        in_valid = 1'b0;
        check("blocked_count", 64'(count), 64'd4);
        check("blocked_head",  out_struct, {32'd1, 32'd101});
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_%0d", i), out_struct, {32'(i), 32'(100 + i)});
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        check("drain_out_int",   64'(out_int),   64'd10);
        check("drain_out_valid", 64'(out_valid), 64'd0);

        // Full plus pop in the same cycle: push is refused.
        for (int i = 11; i <= 14; i++) begin
            in_valid  = 1'b1;
            in_struct = '{a: 32'(i), b: 32'd0};
            step();
        end
        in_struct = '{a: 32'd55, b: 32'd0};
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        check("fullpop_count",    64'(count),    64'd3);
        check("fullpop_in_ready", 64'(in_ready), 64'd1);
        check("fullpop_out_int",  64'(out_int),  64'd21);
        check("fullpop_head",     out_struct,    {32'd12, 32'd0});
        step();
        out_ready = 1'b0;
        check("pop12_out_int", 64'(out_int), 64'd33);
        check("pop12_count",   64'(count),   64'd2);

        // Simultaneous push/pop at count 2 for 8 cycles; pointers wrap twice.
        exp_q.push_back('{a: 32'd13, b: 32'd0});
        exp_q.push_back('{a: 32'd14, b: 32'd0});
        sum_a = 32'd33;
        for (int k = 0; k < 8; k++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_struct = '{a: 32'(20 + k), b: 32'(k)};
            exp_q.push_back(in_struct);
            head = exp_q.pop_front();
            check($sformatf("stream_head_%0d", k), out_struct, head);
            sum_a = sum_a + head.a;
            step();
            check($sformatf("stream_count_%0d", k), 64'(count), 64'd2);
        end
        in_valid = 1'b0;
        check("stream_out_int", 64'(out_int), 64'(sum_a));
        for (int k = 0; k < 2; k++) begin
            head = exp_q.pop_front();
            check($sformatf("stream_tail_%0d", k), out_struct, {32'(26 + k), 32'(6 + k)});
            check($sformatf("stream_q_%0d", k), out_struct, head);
            step();
        end
        out_ready = 1'b0;
        check("stream_empty", 64'(out_valid), 64'd0);

        // Arithmetic wrap of b and of the running sum.
        pulse_reset();
        in_valid  = 1'b1;
        in_struct = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF};
        in_int    = 32'd2;
        step();
        in_struct = '{a: 32'h8000_0000, b: 32'd5};
        in_int    = 32'd0;
        step();
        in_valid  = 1'b0;
        check("wrap_b", out_struct, {32'h8000_0000, 32'h0000_0001});
        out_ready = 1'b1;
        step();
        check("wrap_second", out_struct, {32'h8000_0000, 32'd5});
        check("wrap_half",   64'(out_int), 64'h8000_0000);
        step();
        out_ready = 1'b0;
        check("wrap_out_int", 64'(out_int), 64'd0);

        // Asynchronous reset mid-cycle with two entries stored.
        in_valid  = 1'b1;
        in_struct = '{a: 32'd7, b: 32'd1};
        step();
        in_struct = '{a: 32'd8, b: 32'd2};
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pre_reset_count", 64'(count),   64'd1);
        check("pre_reset_int",   64'(out_int), 64'd7);
        #2 rst = 1'b1;
        #1;
        check_idle("async_reset");
        rst = 1'b0;
        step();
        check_idle("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
